rx_tlp_trigger_p: RTL and testbench

Parametrised successor of the RX DMA trigger: watches the committed write pointer of the on-chip RX qword buffer and decides when the DMA write engine emits a full TLP, a short page-closing TLP, or a huge-page change. It sits between the buffer writer and the TLP write engine. Buffer depth, TLP size, huge-page size and timeout are generic. The timeout is run-time programmable. The read pointer and page offset are exported.

---
 rtl/rx_trig_pkg.sv | 28 ++
 rtl/rx_trig_timeout.sv | 29 ++
 rtl/rx_tlp_trigger_p.sv | 145 ++++++++++++++
 tb/tb_rx_tlp_trigger_p.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_trig_pkg.sv
// rtl/rx_trig_pkg.sv - shared states, defaults and width helper for the RX DMA TLP trigger.
package rx_trig_pkg;

    localparam int DEF_TLP_QW       = 16;
    localparam int DEF_PAGE_QW_LOG2 = 18;

    localparam logic [5:0] ST_IDLE_V   = 6'b000001;
    localparam logic [5:0] ST_TLP_V    = 6'b000010;
    localparam logic [5:0] ST_LAST_V   = 6'b000100;
    localparam logic [5:0] ST_CHPG_V   = 6'b001000;
    localparam logic [5:0] ST_UPD_V    = 6'b010000;
    localparam logic [5:0] ST_SETTLE_V = 6'b100000;

    typedef enum logic [5:0] {
        ST_IDLE   = ST_IDLE_V,
        ST_TLP    = ST_TLP_V,
        ST_LAST   = ST_LAST_V,
        ST_CHPG   = ST_CHPG_V,
        ST_UPD    = ST_UPD_V,
        ST_SETTLE = ST_SETTLE_V
    } trig_state_t;

    // qwords_to_send must hold TLP_QW itself, hence the extra bit.
    function automatic int qw_cnt_w(input int tlp_qw);
        return $clog2(tlp_qw) + 1;
    endfunction

endpackage

// File: rtl/rx_trig_timeout.sv
// rtl/rx_trig_timeout.sv - idle-cycle counter that flags when buffered residue should be flushed.
module rx_trig_timeout #(
    parameter int TO_W = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_idle,
    input  logic            i_stay,
    input  logic            i_clr,
    input  logic [TO_W-1:0] i_timeout_cycles,
    output logic            o_timeout
);

    logic [TO_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (!i_idle || i_clr) begin
            r_count <= '0;
        end else if (i_stay) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Compare is combinational so a new threshold applies on the very next cycle.
    assign o_timeout = (i_timeout_cycles != '0) && (r_count == i_timeout_cycles - 1'b1);

endmodule

// File: rtl/rx_tlp_trigger_p.sv
// rtl/rx_tlp_trigger_p.sv - decides full TLP / page-closing TLP / huge-page change; RX_TRIG_TIMEOUT_EN enables timeout flush.
module rx_tlp_trigger_p
    import rx_trig_pkg::*;
#(
    parameter int BUF_AW       = 10,
    parameter int TLP_QW       = DEF_TLP_QW,
    parameter int PAGE_QW_LOG2 = DEF_PAGE_QW_LOG2,
    parameter int TO_W         = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [BUF_AW-1:0]           commited_wr_address,
    input  logic [TO_W-1:0]             timeout_cycles,
    output logic                        trigger_tlp,
    input  logic                        trigger_tlp_ack,
    output logic                        send_last_tlp,
    output logic                        change_huge_page,
    input  logic                        change_huge_page_ack,
    output logic [qw_cnt_w(TLP_QW)-1:0] qwords_to_send,
    output logic [BUF_AW-1:0]           commited_rd_address,
    output logic [PAGE_QW_LOG2:0]       page_offset,
    output logic                        busy
);

    localparam int QW_W = qw_cnt_w(TLP_QW);
    localparam int PO_W = PAGE_QW_LOG2 + 1;
    localparam logic [BUF_AW-1:0] TLP_QW_A  = BUF_AW'(TLP_QW);
    localparam logic [PO_W-1:0]   TLP_QW_P  = PO_W'(TLP_QW);
    localparam logic [QW_W-1:0]   TLP_QW_Q  = QW_W'(TLP_QW);
    localparam logic [PO_W-1:0]   PAGE_FULL = {1'b1, {PAGE_QW_LOG2{1'b0}}};

    trig_state_t        r_state;
    trig_state_t        w_state_next;
    logic [BUF_AW-1:0]  r_diff_q;
    logic [BUF_AW-1:0]  r_rd;
    logic [BUF_AW-1:0]  w_rd_next;
    logic [PO_W-1:0]    r_page_off;
    logic [PO_W-1:0]    w_page_off_next;
    logic [QW_W-1:0]    r_qw;
    logic [QW_W-1:0]    w_qw_next;
    logic               w_diff_ge;
    logic               w_page_full;
    logic               w_dirty;
    logic               w_timeout;
    logic               w_stay;

    assign w_diff_ge   = r_diff_q >= TLP_QW_A;
    assign w_page_full = r_page_off == PAGE_FULL;
    assign w_dirty     = r_page_off > TLP_QW_P;

`ifdef RX_TRIG_TIMEOUT_EN
    rx_trig_timeout #(
        .TO_W(TO_W)
    ) u_timeout (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_idle           (r_state == ST_IDLE),
        .i_stay           (w_stay),
        .i_clr            (w_diff_ge),
        .i_timeout_cycles (timeout_cycles),
        .o_timeout        (w_timeout)
    );
`else
    logic w_unused_to;
    assign w_timeout   = 1'b0;
    assign w_unused_to = ^{timeout_cycles, w_stay};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_diff_q   <= '0;
            r_rd       <= '0;
            r_page_off <= TLP_QW_P;
            r_qw       <= '0;
        end else begin
            r_state    <= w_state_next;
            r_diff_q   <= commited_wr_address - r_rd;
            r_rd       <= w_rd_next;
            r_page_off <= w_page_off_next;
            r_qw       <= w_qw_next;
        end
    end

    // Pointer advance is committed on the ack edge so it is visible in UPD;
    // SETTLE then lets diff_q catch up before IDLE looks at it again.
    always_comb begin
        w_state_next    = r_state;
        w_rd_next       = r_rd;
        w_page_off_next = r_page_off;
        w_qw_next       = r_qw;
        w_stay          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_page_full) begin
                    w_state_next = ST_CHPG;
                    w_qw_next    = '0;
                end else if (w_diff_ge) begin
                    w_state_next = ST_TLP;
                    w_qw_next    = TLP_QW_Q;
                end else if (w_timeout && (r_diff_q != '0)) begin
                    w_state_next = ST_LAST;
                    w_qw_next    = QW_W'(r_diff_q);
                end else if (w_timeout && w_dirty) begin
                    w_state_next = ST_CHPG;
                    w_qw_next    = '0;
                end else begin
                    w_stay = 1'b1;
                end
            end
            ST_TLP: begin
                if (trigger_tlp_ack) begin
                    w_state_next    = ST_UPD;
                    w_rd_next       = r_rd + TLP_QW_A;
                    w_page_off_next = r_page_off + TLP_QW_P;
                end
            end
            ST_LAST: begin
                if (change_huge_page_ack) begin
                    w_state_next    = ST_UPD;
                    w_rd_next       = r_rd + BUF_AW'(r_qw);
                    w_page_off_next = TLP_QW_P;
                end
            end
            ST_CHPG: begin
                if (change_huge_page_ack) begin
                    w_state_next    = ST_UPD;
                    w_page_off_next = TLP_QW_P;
                end
            end
            ST_UPD:    w_state_next = ST_SETTLE;
            ST_SETTLE: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    assign trigger_tlp         = r_state == ST_TLP;
    assign send_last_tlp       = r_state == ST_LAST;
    assign change_huge_page    = r_state == ST_CHPG;
    assign busy                = r_state != ST_IDLE;
    assign qwords_to_send      = r_qw;
    assign commited_rd_address = r_rd;
    assign page_offset         = r_page_off;

endmodule

// File: tb/tb_rx_tlp_trigger_p.sv
// tb/tb_rx_tlp_trigger_p.sv - directed self-checking bench for rx_tlp_trigger_p.
module tb_rx_tlp_trigger_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [9:0]  wr_a, rd_a, wr_b, rd_b;
    logic [15:0] to_a, to_b;
    logic        trig_a, tack_a, last_a, chpg_a, cack_a, busy_a;
    logic        trig_b, tack_b, last_b, chpg_b, cack_b, busy_b;
    logic [4:0]  qw_a, qw_b;
    logic [18:0] off_a;
    logic [6:0]  off_b;

    int checks   = 0;
    int failures = 0;
    int n, q;
    bit seen;

    rx_tlp_trigger_p dut_a (
        .clk                  (clk),
        .reset_n              (reset_n),
        .commited_wr_address  (wr_a),
        .timeout_cycles       (to_a),
        .trigger_tlp          (trig_a),
        .trigger_tlp_ack      (tack_a),
        .send_last_tlp        (last_a),
        .change_huge_page     (chpg_a),
        .change_huge_page_ack (cack_a),
        .qwords_to_send       (qw_a),
        .commited_rd_address  (rd_a),
        .page_offset          (off_a),
        .busy                 (busy_a)
    );

    rx_tlp_trigger_p #(.PAGE_QW_LOG2(6)) dut_b (
        .clk                  (clk),
        .reset_n              (reset_n),
        .commited_wr_address  (wr_b),
        .timeout_cycles       (to_b),
        .trigger_tlp          (trig_b),
        .trigger_tlp_ack      (tack_b),
        .send_last_tlp        (last_b),
        .change_huge_page     (chpg_b),
        .change_huge_page_ack (cack_b),
        .qwords_to_send       (qw_b),
        .commited_rd_address  (rd_b),
        .page_offset          (off_b),
        .busy                 (busy_b)
    );

    task automatic tick(input int cnt);
        repeat (cnt) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    task automatic serve_a(input int dly, output int qw);
        int k = 0;
        while (!trig_a && k < 200) begin
            tick(1);
            k++;
        end
        chk("a_tlp_seen", {31'b0, trig_a}, 32'd1);
        qw = int'(qw_a);
        tick(dly);
        tack_a = 1'b1;
        tick(1);
        tack_a = 1'b0;
    endtask

    task automatic serve_b(input int dly, output int qw);
        int k = 0;
        while (!trig_b && k < 200) begin
            tick(1);
            k++;
        end
        chk("b_tlp_seen", {31'b0, trig_b}, 32'd1);
        qw = int'(qw_b);
        tick(dly);
        tack_b = 1'b1;
        tick(1);
        tack_b = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        wr_a = '0; wr_b = '0; to_a = '0; to_b = '0;
        tack_a = 1'b0; cack_a = 1'b0; tack_b = 1'b0; cack_b = 1'b0;
        tick(3);
        chk("rst_trig",  {31'b0, trig_a}, 32'd0);
        chk("rst_last",  {31'b0, last_a}, 32'd0);
        chk("rst_chpg",  {31'b0, chpg_a}, 32'd0);
        chk("rst_qw",    32'(qw_a), 32'd0);
        chk("rst_rd",    32'(rd_a), 32'd0);
        chk("rst_off",   32'(off_a), 32'd16);
        chk("rst_busy",  {31'b0, busy_a}, 32'd0);
        chk("rst_off_b", 32'(off_b), 32'd16);
        reset_n = 1'b1;
        tick(1);

        // Two full TLPs from 40 qwords, 8 left behind.
        wr_a = 10'd40;
        serve_a(2, q);
        chk("t1_qw0", 32'(q), 32'd16);
        serve_a(2, q);
        chk("t1_qw1", 32'(q), 32'd16);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (trig_a || last_a || chpg_a) seen = 1'b1;
        end
        chk("t1_no_more", {31'b0, seen}, 32'd0);
        chk("t1_rd",   32'(rd_a), 32'd32);
        chk("t1_off",  32'(off_a), 32'd48);
        chk("t1_busy", {31'b0, busy_a}, 32'd0);

        // Residue flush after the idle timeout.
        wr_a = 10'd5;
        to_a = 16'd100;
        apply_reset();
`ifdef RX_TRIG_TIMEOUT_EN
        n = 0;
        while (!last_a && n < 300) begin
            tick(1);
            n++;
        end
        chk("t2_latency", 32'(n), 32'd100);
        chk("t2_last", {31'b0, last_a}, 32'd1);
        chk("t2_qw", 32'(qw_a), 32'd5);
        cack_a = 1'b1;
        tick(1);
        cack_a = 1'b0;
        tick(4);
        chk("t2_rd",  32'(rd_a), 32'd5);
        chk("t2_off", 32'(off_a), 32'd16);
        chk("t2_last_done", {31'b0, last_a}, 32'd0);
`else
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (trig_a || last_a || chpg_a) seen = 1'b1;
        end
        chk("t2_no_flush", {31'b0, seen}, 32'd0);
        chk("t2_rd", 32'(rd_a), 32'd0);
`endif
        to_a = 16'd0;

        // 64-qword page: three TLPs fill it, then a data-less page change.
        wr_b = 10'd100;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            serve_b(1, q);
            chk("t3_qw", 32'(q), 32'd16);
        end
        n = 0;
        while (!chpg_b && n < 20) begin
            tick(1);
            n++;
        end
        chk("t3_chpg", {31'b0, chpg_b}, 32'd1);
        chk("t3_off_full", 32'(off_b), 32'd64);
        chk("t3_rd_before", 32'(rd_b), 32'd48);
        chk("t3_qw_chpg", 32'(qw_b), 32'd0);
        cack_b = 1'b1;
        tick(1);
        cack_b = 1'b0;
        chk("t3_rd_after", 32'(rd_b), 32'd48);
        chk("t3_off_after", 32'(off_b), 32'd16);
        chk("t3_chpg_low", {31'b0, chpg_b}, 32'd0);
        wr_b = 10'd0;

        // Drain to rd=1008, then a write pointer that wraps past zero.
        wr_a = 10'd1020;
        apply_reset();
        for (int i = 0; i < 63; i++) serve_a(0, q);
        tick(10);
        chk("t4_rd_1008", 32'(rd_a), 32'd1008);
        chk("t4_idle", {31'b0, trig_a}, 32'd0);
        wr_a = 10'd12;
        serve_a(0, q);
        chk("t4_qw", 32'(q), 32'd16);
        tick(4);
        chk("t4_rd_wrap", 32'(rd_a), 32'd0);
        tick(20);
        chk("t4_no_more", {31'b0, trig_a}, 32'd0);

        // Reset while a full TLP is waiting for its ack.
        wr_a = 10'd40;
        apply_reset();
        n = 0;
        while (!trig_a && n < 20) begin
            tick(1);
            n++;
        end
        chk("t5_pending", {31'b0, trig_a}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_trig", {31'b0, trig_a}, 32'd0);
        chk("t5_busy", {31'b0, busy_a}, 32'd0);
        chk("t5_qw",   32'(qw_a), 32'd0);
        chk("t5_off",  32'(off_a), 32'd16);
        wr_a = 10'd0;
        tick(2);
        reset_n = 1'b1;
        tick(3);
        chk("t5_busy_after", {31'b0, busy_a}, 32'd0);
        chk("t5_rd_after",   32'(rd_a), 32'd0);
        chk("t5_off_after",  32'(off_a), 32'd16);

        // Timeout disabled: a 3-qword residue is never flushed.
        wr_a = 10'd3;
        to_a = 16'd0;
        apply_reset();
        seen = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            tick(1);
            if (trig_a || last_a || chpg_a) seen = 1'b1;
        end
        chk("t6_no_req", {31'b0, seen}, 32'd0);
        chk("t6_rd", 32'(rd_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
